// File: rtl/exp_vector_scan.sv
// -----------------------------------------------------------------------------
// exp_vector_scan
//
// Walks a 3-bit test vector {a,b,c} through 000..111 into a downstream
// combinational stage, waits SETTLE_CYCLES clocks per vector for the stage to
// settle, samples its answer y_in, and assembles the 8-entry truth table in
// tbl. At the end of a scan the captured table is compared against EXP_TABLE.
//
// Parameters
//   SETTLE_CYCLES : cycles {a,b,c} is held before y_in is sampled (0..15)
//   EXP_TABLE     : expected truth table, bit i = expected y for {a,b,c}=i
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request a scan (only honoured while idle)
//   y_in     in   downstream result, sampled in the same cycle it is used
//   a,b,c    out  vector to the downstream stage (a = MSB)
//   busy     out  high while a scan is in progress
//   done     out  one-cycle pulse at the end of each scan
//   tbl      out  captured truth table
//   mismatch out  tbl != EXP_TABLE, valid from done onward
//   scan_cnt out  completed scans, saturating at 255
//
// Build option
//   EXP_SCAN_LOOP_EN : when defined, a scan restarts immediately after DONE
//                      and keeps looping until rst_n is asserted.
// -----------------------------------------------------------------------------
module exp_vector_scan #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXP_TABLE     = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] tbl,
    output logic       mismatch,
    output logic [7:0] scan_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // With no settle time a vector is sampled in the very cycle it is first
    // driven, so SETTLE is bypassed entirely to keep one cycle per vector.
    localparam state_t     VEC_ENTRY   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    // The settle counter counts down to zero, so it is loaded with N-1.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0
                                                              : 4'(SETTLE_CYCLES - 1);

    state_t     state_q,    state_d;
    logic [2:0] idx_q,      idx_d;
    logic [3:0] cnt_q,      cnt_d;
    logic [7:0] tbl_q,      tbl_d;
    logic       mism_q,     mism_d;
    logic [7:0] scan_cnt_q, scan_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 4'd0;
            tbl_q      <= 8'h00;
            mism_q     <= 1'b0;
            scan_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tbl_q      <= tbl_d;
            mism_q     <= mism_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tbl_d      = tbl_q;
        mism_d     = mism_q;
        scan_cnt_d = scan_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = VEC_ENTRY;
                    idx_d   = 3'd0;
                    cnt_d   = SETTLE_LOAD;
                    tbl_d   = 8'h00;
                    mism_d  = 1'b0;
                end
            end

            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            SAMPLE: begin
                tbl_d[idx_q] = y_in;
                if (idx_q == 3'd7) begin
                    state_d = DONE;
                    // Compare against the table including the bit written
                    // now, so mismatch is already valid while done is high.
                    mism_d  = (tbl_d != EXP_TABLE);
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = VEC_ENTRY;
                end
            end

            DONE: begin
                if (scan_cnt_q != 8'd255) begin
                    scan_cnt_d = scan_cnt_q + 8'd1;
                end
`ifdef EXP_SCAN_LOOP_EN
                state_d = VEC_ENTRY;
                idx_d   = 3'd0;
                cnt_d   = SETTLE_LOAD;
                tbl_d   = 8'h00;
`else
                state_d = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state so reset clears them
    // immediately, without waiting for a clock edge.
    assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign {a, b, c} = busy ? idx_q : 3'b000;
    assign tbl       = tbl_q;
    assign mismatch  = mism_q;
    assign scan_cnt  = scan_cnt_q;

endmodule

// File: tb/tb_exp_vector_scan.sv
module tb_exp_vector_scan;

    localparam int         S2 = 2;
    localparam logic [7:0] E2 = 8'hEA;
    localparam int         S0 = 0;
    localparam logic [7:0] E0 = 8'h00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start2, y2, a2, b2, c2, busy2, done2, mm2;
    logic [7:0] tbl2, cnt2;
    logic       start0, y0, a0, b0, c0, busy0, done0, mm0;
    logic [7:0] tbl0, cnt0;

    int fn2 = 0;
    int fn0 = 0;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cnt_m2 = 8'd0;
    logic [7:0] cnt_m0 = 8'd0;

    // Downstream stage model: 0 -> a&b|c, 1 -> a^b, other -> constant 0
    function automatic logic yfun(input int f, input logic [2:0] v);
        case (f)
            0:       return (v[2] & v[1]) | v[0];
            1:       return v[2] ^ v[1];
            default: return 1'b0;
        endcase
    endfunction

    assign y2 = yfun(fn2, {a2, b2, c2});
    assign y0 = yfun(fn0, {a0, b0, c0});

    exp_vector_scan #(.SETTLE_CYCLES(S2), .EXP_TABLE(E2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .y_in(y2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2),
        .tbl(tbl2), .mismatch(mm2), .scan_cnt(cnt2)
    );

    exp_vector_scan #(.SETTLE_CYCLES(S0), .EXP_TABLE(E0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0),
        .tbl(tbl0), .mismatch(mm0), .scan_cnt(cnt0)
    );

    function automatic logic [2:0] vec_of(input int sel);
        return (sel == 0) ? {a0, b0, c0} : {a2, b2, c2};
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy0 : busy2;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel == 0) ? done0 : done2;
    endfunction
    function automatic logic mm_of(input int sel);
        return (sel == 0) ? mm0 : mm2;
    endfunction
    function automatic logic [7:0] tbl_of(input int sel);
        return (sel == 0) ? tbl0 : tbl2;
    endfunction
    function automatic logic [7:0] cnt_of(input int sel);
        return (sel == 0) ? cnt0 : cnt2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int sel);
        chk("rst_vec",  32'(vec_of(sel)),  32'd0);
        chk("rst_busy", 32'(busy_of(sel)), 32'd0);
        chk("rst_done", 32'(done_of(sel)), 32'd0);
        chk("rst_tbl",  32'(tbl_of(sel)),  32'd0);
        chk("rst_mm",   32'(mm_of(sel)),   32'd0);
        chk("rst_cnt",  32'(cnt_of(sel)),  32'd0);
    endtask

    // Scoreboard: expected table is computed from the model at launch time.
    task automatic push_exp(input int f);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = yfun(f, 3'(i));
        exp_q.push_back(t);
    endtask

    // Returns #1 after the edge that samples start (edge 0).
    task automatic launch(input int sel);
        @(posedge clk);
        #1;
        if (sel == 0) start0 = 1'b1;
        else          start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    // Entered #1 after edge 0; walks a fixed number of edges, so it is bounded.
    task automatic wait_scan(input int sel, input bit mid_start);
        int         s;
        int         lat;
        logic [7:0] e;
        logic [7:0] t;
        logic [7:0] tbl_seen;
        logic       mm_seen;
        s   = (sel == 0) ? S0 : S2;
        e   = (sel == 0) ? E0 : E2;
        lat = 8 * (s + 1);
        for (int n = 0; n < lat; n++) begin
            if (n == 0) begin
                chk("mm_cleared",  32'(mm_of(sel)),  32'd0);
                chk("tbl_cleared", 32'(tbl_of(sel)), 32'd0);
            end
            chk("busy_scan",  32'(busy_of(sel)), 32'd1);
            chk("done_early", 32'(done_of(sel)), 32'd0);
            chk("vec_step",   32'(vec_of(sel)),  32'(n / (s + 1)));
            if (mid_start && n == 3 * (s + 1)) begin
                if (sel == 0) start0 = 1'b1;
                else          start2 = 1'b1;
            end
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start2 = 1'b0;
        end
        chk("done_pulse", 32'(done_of(sel)), 32'd1);
        chk("busy_done",  32'(busy_of(sel)), 32'd0);
        chk("vec_done",   32'(vec_of(sel)),  32'd0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            t = 8'h00;
        end else begin
            t = exp_q.pop_front();
        end
        chk("tbl",      32'(tbl_of(sel)), 32'(t));
        chk("mismatch", 32'(mm_of(sel)),  32'(t != e));
        tbl_seen = tbl_of(sel);
        mm_seen  = mm_of(sel);
        if (sel == 0) cnt_m0 = (cnt_m0 == 8'd255) ? 8'd255 : cnt_m0 + 8'd1;
        else          cnt_m2 = (cnt_m2 == 8'd255) ? 8'd255 : cnt_m2 + 8'd1;
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done_of(sel)), 32'd0);
        chk("busy_idle",      32'(busy_of(sel)), 32'd0);
        chk("scan_cnt",       32'(cnt_of(sel)),  32'((sel == 0) ? cnt_m0 : cnt_m2));
        chk("tbl_hold",       32'(tbl_of(sel)),  32'(tbl_seen));
        chk("mm_hold",        32'(mm_of(sel)),   32'(mm_seen));
    endtask

    bit loop_d;

    initial begin
        start0 = 1'b0;
        start2 = 1'b0;
        #12;
        check_reset_outputs(2);
        check_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef EXP_SCAN_LOOP_EN
        fn2 = 0;
        launch(2);
        chk("loop_busy0", 32'(busy2), 32'd1);
        for (int n = 1; n <= 24 + 2 * 25 + 1; n++) begin
            @(posedge clk);
            #1;
            loop_d = (n >= 24) && (((n - 24) % 25) == 0);
            chk("loop_done", 32'(done2), 32'(loop_d));
            if (loop_d) begin
                chk("loop_tbl", 32'(tbl2), 32'hEA);
                chk("loop_mm",  32'(mm2),  32'd0);
            end
            if (n >= 25 && ((n - 25) % 25) == 0) begin
                chk("loop_cnt",  32'(cnt2),  32'((n - 25) / 25 + 1));
                chk("loop_busy", 32'(busy2), 32'd1);
            end
        end
        chk("loop_other_idle", 32'(busy0), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(2);
`else
        // Basic scan, a&b|c -> EA, matches EXP_TABLE
        fn2 = 0;
        push_exp(0);
        launch(2);
        wait_scan(2, 1'b0);

        // Mismatch a^b -> 3C, then matching function again
        fn2 = 1;
        push_exp(1);
        launch(2);
        wait_scan(2, 1'b0);
        fn2 = 0;
        push_exp(0);
        launch(2);
        wait_scan(2, 1'b0);

        // Zero settle: one vector per cycle
        fn0 = 0;
        push_exp(0);
        launch(0);
        wait_scan(0, 1'b0);
        fn0 = 2;
        push_exp(2);
        launch(0);
        wait_scan(0, 1'b0);

        // Start pulsed mid-scan is ignored
        fn2 = 1;
        push_exp(1);
        launch(2);
        wait_scan(2, 1'b1);

        // Reset at vector 5, then a start held across reset release
        fn2 = 0;
        launch(2);
        repeat (15) @(posedge clk);
        #1;
        chk("pre_reset_vec", 32'(vec_of(2)), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(2);
        check_reset_outputs(0);
        cnt_m2 = 8'd0;
        cnt_m0 = 8'd0;
        push_exp(0);
        start2 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_scan(2, 1'b0);

        // Saturation: 257 scans on the zero-settle instance
        fn0 = 0;
        for (int k = 0; k < 257; k++) begin
            push_exp(0);
            launch(0);
            wait_scan(0, 1'b0);
        end
        chk("scan_cnt_sat", 32'(cnt0), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
